// File: rtl/gsim_param.sv
// gsim_param: parametrised Gauss-Seidel solver for A*x = b.
//
// For each of the latched number of systems the core loads b, then sweeps
// the N rows of A (one outstanding rreq/rrdy request at a time), updating
// x in place. Sweeps repeat until the iteration limit is reached or, with a
// non-zero tolerance, until the largest per-element change in a sweep is
// within tolerance. The saturated x vector is then streamed to the result
// memory.
//
// Ports:
//   i_clk, i_rst_n              clock (rising edge), async active-low reset
//   i_module_en                 start; held high for the whole job
//   i_matrix_num, i_iter_num    number of systems, max iterations (0 -> 1)
//   i_tol                       unsigned tolerance in Q.FW, 0 disables early exit
//   o_proc_done                 job complete (held while i_module_en is high)
//   o_mem_rreq, o_mem_addr      matrix-memory read request / address
//   i_mem_rrdy                  memory accepts the request this cycle
//   i_mem_dout, i_mem_dout_vld  row data (lane k at [CW*k +: CW]) and valid
//   o_x_wen, o_x_addr           result write strobe / address
//   o_x_iter, o_x_data          iterations run, result value
module gsim_param #(
    parameter int N   = 16,
    parameter int CW  = 16,
    parameter int XW  = 32,
    parameter int FW  = 16,
    parameter int RFW = 14,
    parameter int AW  = 10,
    parameter int XAW = 9,
    parameter int MW  = 5,
    parameter int IW  = 6
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_module_en,
    input  logic [MW-1:0]   i_matrix_num,
    input  logic [IW-1:0]   i_iter_num,
    input  logic [XW-1:0]   i_tol,
    output logic            o_proc_done,
    output logic            o_mem_rreq,
    output logic [AW-1:0]   o_mem_addr,
    input  logic            i_mem_rrdy,
    input  logic [N*CW-1:0] i_mem_dout,
    input  logic            i_mem_dout_vld,
    output logic            o_x_wen,
    output logic [XAW-1:0]  o_x_addr,
    output logic [IW-1:0]   o_x_iter,
    output logic [XW-1:0]   o_x_data
);

    localparam int RW   = $clog2(N);
    localparam int PRW  = CW + XW;
    localparam int ACCW = CW + XW + $clog2(N) + 1;
    localparam int PW   = ACCW + CW;
    localparam int DW   = XW + 1;

    typedef enum logic [2:0] {
        IDLE, LOAD_B, ROW_REQ, ROW_WAIT, CHECK, WRITE, DONE
    } state_t;

    state_t               state;
    logic [MW-1:0]        count_r;
    logic [IW-1:0]        iter_num_r;
    logic [XW-1:0]        tol_r;
    logic [MW-1:0]        m;
    logic [AW-1:0]        base;
    logic [XAW-1:0]       xbase;
    logic [RW-1:0]        row;
    logic [RW-1:0]        wr_idx;
    logic [IW-1:0]        iter;
    logic [DW-1:0]        maxdelta;
    logic signed [XW-1:0] x [N];
    logic signed [CW-1:0] b [N];

    // Row update datapath
    logic signed [PRW-1:0]  prod;
    logic signed [ACCW-1:0] acc;
    logic signed [CW-1:0]   inv;
    logic signed [PW-1:0]   shifted;
    logic signed [XW-1:0]   x_new;
    logic signed [DW-1:0]   diff;
    logic [DW-1:0]          delta;

    always_comb begin
        prod = '0;
        acc  = ACCW'(b[row]) <<< FW;
        for (int unsigned j = 0; j < N; j++) begin
            if (RW'(j) != row) begin
                prod = PRW'($signed(i_mem_dout[CW*j +: CW])) * PRW'(x[j]);
                acc  = acc - ACCW'(prod);
            end
        end
        inv     = $signed(i_mem_dout[CW*row +: CW]);
        shifted = (PW'(acc) * PW'(inv)) >>> RFW;
        // Fits in XW bits when all bits above the XW-1 sign bit agree
        if (shifted[PW-1:XW-1] == '0 || shifted[PW-1:XW-1] == '1)
            x_new = shifted[XW-1:0];
        else if (shifted[PW-1])
            x_new = {1'b1, {(XW-1){1'b0}}};
        else
            x_new = {1'b0, {(XW-1){1'b1}}};
        diff  = DW'(x_new) - DW'(x[row]);
        delta = diff[DW-1] ? DW'(-diff) : DW'(diff);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            count_r     <= '0;
            iter_num_r  <= '0;
            tol_r       <= '0;
            m           <= '0;
            base        <= '0;
            xbase       <= '0;
            row         <= '0;
            wr_idx      <= '0;
            iter        <= '0;
            maxdelta    <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                x[k] <= '0;
                b[k] <= '0;
            end
            o_proc_done <= 1'b0;
            o_mem_rreq  <= 1'b0;
            o_mem_addr  <= '0;
            o_x_wen     <= 1'b0;
            o_x_addr    <= '0;
            o_x_iter    <= '0;
            o_x_data    <= '0;
        end else begin
            o_x_wen <= 1'b0;
            case (state)
                IDLE: begin
                    o_proc_done <= 1'b0;
                    if (i_module_en) begin
                        count_r    <= i_matrix_num;
                        iter_num_r <= (i_iter_num == '0) ? IW'(1) : i_iter_num;
                        tol_r      <= i_tol;
                        m          <= '0;
                        base       <= '0;
                        xbase      <= '0;
                        if (i_matrix_num == '0) begin
                            state <= DONE;
                        end else begin
                            state      <= LOAD_B;
                            o_mem_rreq <= 1'b1;
                            o_mem_addr <= AW'(N);
                        end
                    end
                end
                // rreq high: waiting for acceptance; rreq low: waiting for data
                LOAD_B: begin
                    if (o_mem_rreq) begin
                        if (i_mem_rrdy)
                            o_mem_rreq <= 1'b0;
                    end else if (i_mem_dout_vld) begin
                        for (int unsigned k = 0; k < N; k++) begin
                            b[k] <= $signed(i_mem_dout[CW*k +: CW]);
                            x[k] <= '0;
                        end
                        iter       <= '0;
                        row        <= '0;
                        maxdelta   <= '0;
                        state      <= ROW_REQ;
                        o_mem_rreq <= 1'b1;
                        o_mem_addr <= base;
                    end
                end
                ROW_REQ: begin
                    if (i_mem_rrdy) begin
                        o_mem_rreq <= 1'b0;
                        state      <= ROW_WAIT;
                    end
                end
                ROW_WAIT: begin
                    if (i_mem_dout_vld) begin
                        x[row] <= x_new;
                        if (delta > maxdelta)
                            maxdelta <= delta;
                        if (row == RW'(N - 1)) begin
                            state <= CHECK;
                        end else begin
                            row        <= row + RW'(1);
                            state      <= ROW_REQ;
                            o_mem_rreq <= 1'b1;
                            o_mem_addr <= base + AW'(row) + AW'(1);
                        end
                    end
                end
                CHECK: begin
                    iter <= iter + IW'(1);
                    if ((iter + IW'(1) == iter_num_r) ||
                        (tol_r != '0 && maxdelta <= {1'b0, tol_r})) begin
                        state  <= WRITE;
                        wr_idx <= '0;
                    end else begin
                        row        <= '0;
                        maxdelta   <= '0;
                        state      <= ROW_REQ;
                        o_mem_rreq <= 1'b1;
                        o_mem_addr <= base;
                    end
                end
                WRITE: begin
                    o_x_wen  <= 1'b1;
                    o_x_addr <= xbase + XAW'(wr_idx);
                    o_x_data <= x[wr_idx];
                    o_x_iter <= iter;
                    if (wr_idx == RW'(N - 1)) begin
                        if (m == count_r - MW'(1)) begin
                            state <= DONE;
                        end else begin
                            m          <= m + MW'(1);
                            base       <= base + AW'(N + 1);
                            xbase      <= xbase + XAW'(N);
                            state      <= LOAD_B;
                            o_mem_rreq <= 1'b1;
                            // b row of the next system: next base + N
                            o_mem_addr <= base + AW'(2 * N + 1);
                        end
                    end else begin
                        wr_idx <= wr_idx + RW'(1);
                    end
                end
                DONE: begin
                    if (i_module_en) begin
                        o_proc_done <= 1'b1;
                    end else begin
                        o_proc_done <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_param.sv
// Testbench for gsim_param: randomized memory timing (rrdy stalls, variable
// read latency), a higher-level Gauss-Seidel reference model using wide
// integer arithmetic, and a scoreboard checked by an independent monitor.
module tb_gsim_param;

    localparam int N   = 16;
    localparam int CW  = 16;
    localparam int XW  = 32;
    localparam int FW  = 16;
    localparam int RFW = 14;
    localparam int AW  = 10;
    localparam int XAW = 9;
    localparam int MW  = 5;
    localparam int IW  = 6;
    localparam int BUDGET = 30000;

    typedef logic signed [127:0] wide_t;
    typedef struct {
        int unsigned  addr;
        logic [XW-1:0] data;
        int unsigned  iter;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            module_en;
    logic [MW-1:0]   matrix_num;
    logic [IW-1:0]   iter_num;
    logic [XW-1:0]   tol;
    logic            proc_done;
    logic            mem_rreq;
    logic [AW-1:0]   mem_addr;
    logic            mem_rrdy;
    logic [N*CW-1:0] mem_dout;
    logic            mem_vld;
    logic            x_wen;
    logic [XAW-1:0]  x_addr;
    logic [IW-1:0]   x_iter;
    logic [XW-1:0]   x_data;

    logic [N*CW-1:0] mem [0:(1<<AW)-1];
    int unsigned rq[$];
    wr_t         wq[$];
    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int stall_req = 0;
    bit expect_early = 0;
    bit expect_full = 0;

    gsim_param #(
        .N(N), .CW(CW), .XW(XW), .FW(FW), .RFW(RFW),
        .AW(AW), .XAW(XAW), .MW(MW), .IW(IW)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_module_en(module_en),
        .i_matrix_num(matrix_num),
        .i_iter_num(iter_num),
        .i_tol(tol),
        .o_proc_done(proc_done),
        .o_mem_rreq(mem_rreq),
        .o_mem_addr(mem_addr),
        .i_mem_rrdy(mem_rrdy),
        .i_mem_dout(mem_dout),
        .i_mem_dout_vld(mem_vld),
        .o_x_wen(x_wen),
        .o_x_addr(x_addr),
        .o_x_iter(x_iter),
        .o_x_data(x_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({proc_done, mem_rreq, mem_addr, x_wen, x_addr, x_iter, x_data});
    endfunction

    function automatic wide_t lane(input logic [N*CW-1:0] r, input int k);
        logic signed [CW-1:0] t;
        t = r[CW*k +: CW];
        return t;
    endfunction

    // Diagonally dominant random system: lane i holds ~1/d, |a_ij| <= 2
    task automatic gen_random(input int m);
        logic [N*CW-1:0] r;
        int d, v;
        for (int i = 0; i < N; i++) begin
            d = int'($urandom_range(64, 127));
            for (int j = 0; j < N; j++) begin
                v = (j == i) ? (16384 / d) : (int'($urandom_range(0, 4)) - 2);
                r[CW*j +: CW] = CW'(v);
            end
            mem[m*(N+1)+i] = r;
        end
        for (int j = 0; j < N; j++) begin
            v = int'($urandom_range(0, 4000)) - 2000;
            r[CW*j +: CW] = CW'(v);
        end
        mem[m*(N+1)+N] = r;
    endtask

    // Diagonal system: row 0 reciprocal inv0 / b0, other rows 0x2000 / brest
    task automatic gen_diag(input int m, input logic [CW-1:0] inv0,
                            input logic [CW-1:0] b0, input logic [CW-1:0] brest);
        logic [N*CW-1:0] r;
        for (int i = 0; i < N; i++) begin
            r = '0;
            r[CW*i +: CW] = (i == 0) ? inv0 : 16'h2000;
            mem[m*(N+1)+i] = r;
        end
        for (int j = 0; j < N; j++) r[CW*j +: CW] = (j == 0) ? b0 : brest;
        mem[m*(N+1)+N] = r;
    endtask

    task automatic push_reads_one_iter(input int mnum);
        for (int m = 0; m < mnum; m++) begin
            rq.push_back(m*(N+1)+N);
            for (int i = 0; i < N; i++) rq.push_back(m*(N+1)+i);
        end
    endtask

    task automatic push_write(input int unsigned a, input logic [XW-1:0] d, input int unsigned it);
        wr_t e;
        e.addr = a; e.data = d; e.iter = it;
        wq.push_back(e);
    endtask

    // Reference: plain Gauss-Seidel on unbounded integers, floor division by
    // 2^RFW, clamp to the XW-bit signed range.
    task automatic model_job(input int mnum, input int itn, input logic [XW-1:0] tl);
        wide_t xs [N];
        wide_t acc, v, d, maxd, xmax, xmin, tolw;
        logic [N*CW-1:0] r, bv;
        int eff, it, base;
        xmax = (wide_t'(1) <<< (XW-1)) - 1;
        xmin = -(wide_t'(1) <<< (XW-1));
        tolw = 0;
        tolw[XW-1:0] = tl;
        eff = (itn == 0) ? 1 : itn;
        for (int m = 0; m < mnum; m++) begin
            base = m * (N + 1);
            rq.push_back(base + N);
            bv = mem[base + N];
            for (int k = 0; k < N; k++) xs[k] = 0;
            it = 0;
            do begin
                maxd = 0;
                for (int i = 0; i < N; i++) begin
                    rq.push_back(base + i);
                    r = mem[base + i];
                    acc = lane(bv, i) * (wide_t'(1) <<< FW);
                    for (int j = 0; j < N; j++)
                        if (j != i) acc = acc - lane(r, j) * xs[j];
                    v = (acc * lane(r, i)) >>> RFW;
                    if (v > xmax) v = xmax;
                    if (v < xmin) v = xmin;
                    d = v - xs[i];
                    if (d < 0) d = -d;
                    if (d > maxd) maxd = d;
                    xs[i] = v;
                end
                it++;
            end while (!(it == eff || (tl != 0 && maxd <= tolw)));
            for (int i = 0; i < N; i++) push_write(m*N + i, xs[i][XW-1:0], it);
        end
    endtask

    // Memory: random rrdy, random latency 1..3, one outstanding request
    initial begin : mem_model
        int cnt;
        bit pending, prev_req, prev_rdy;
        int unsigned paddr, e;
        logic [AW-1:0] prev_addr;
        cnt = 0; pending = 0; prev_req = 0; prev_rdy = 0; paddr = 0; prev_addr = '0;
        mem_rrdy = 1'b0; mem_vld = 1'b0; mem_dout = '0;
        forever begin
            @(negedge clk);
            mem_vld = 1'b0;
            if (!rst_n) begin
                pending = 0; prev_req = 0; prev_rdy = 0;
                mem_rrdy = 1'b0;
            end else begin
                if (prev_req && !prev_rdy)
                    chk(mem_rreq && mem_addr == prev_addr, "req_hold",
                        64'({mem_rreq, mem_addr}), 64'({1'b1, prev_addr}));
                if (pending) begin
                    cnt--;
                    if (cnt == 0) begin
                        pending = 0;
                        mem_vld = 1'b1;
                        mem_dout = mem[paddr];
                    end
                end
                mem_rrdy = 1'b0;
                if (mem_rreq && !pending) begin
                    if (stall_req > 0) stall_req--;
                    else mem_rrdy = ($urandom_range(0, 3) != 0);
                    if (mem_rrdy) begin
                        accepts++;
                        e = (rq.size() != 0) ? rq.pop_front() : 32'hFFFF_FFFF;
                        chk(mem_addr == AW'(e) && e != 32'hFFFF_FFFF, "read_addr", 64'(mem_addr), 64'(e));
                        paddr = int'(mem_addr);
                        pending = 1;
                        cnt = int'($urandom_range(1, 3));
                    end
                end
                prev_req = mem_rreq;
                prev_rdy = mem_rrdy;
                prev_addr = mem_addr;
            end
        end
    end

    // Scoreboard monitor for result writes
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && x_wen) begin
                if (wq.size() == 0) begin
                    chk(wq.size() != 0, "unexpected_write", 64'(x_addr), 64'(0));
                end else begin
                    e = wq.pop_front();
                    chk(x_addr == XAW'(e.addr), "x_addr", 64'(x_addr), 64'(e.addr));
                    chk(x_data == e.data, "x_data", 64'(x_data), 64'(e.data));
                    chk(x_iter == IW'(e.iter), "x_iter", 64'(x_iter), 64'(e.iter));
                    if (expect_early) chk(x_iter < 6'd63, "early_exit_iter", 64'(x_iter), 64'(63));
                    if (expect_full) chk(x_iter == 6'd63, "full_iter", 64'(x_iter), 64'(63));
                end
            end
        end
    end

    task automatic run_job(input int mnum, input int itn, input logic [XW-1:0] tl, output int cyc);
        matrix_num = MW'(mnum);
        iter_num = IW'(itn);
        tol = tl;
        module_en = 1'b1;
        cyc = 0;
        while (!proc_done && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        chk(proc_done, "proc_done", 64'(proc_done), 64'(1));
        chk(wq.size() == 0, "writes_left", 64'(wq.size()), 64'(0));
        chk(rq.size() == 0, "reads_left", 64'(rq.size()), 64'(0));
        module_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk(!proc_done, "done_clear", 64'(proc_done), 64'(0));
        rq.delete();
        wq.delete();
    endtask

    initial begin : main
        int n;
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        rst_n = 1'b0; module_en = 1'b0; matrix_num = '0; iter_num = '0; tol = '0;
        repeat (3) @(negedge clk);
        chk(outs() == 64'd0, "reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Diagonal 2I, b=4, with a 5-cycle rrdy stall on the first request
        gen_diag(0, 16'h2000, 16'd4, 16'd4);
        push_reads_one_iter(1);
        for (int i = 0; i < N; i++) push_write(i, 32'h0002_0000, 1);
        stall_req = 5;
        run_job(1, 1, '0, n);

        // Saturation at both rails
        gen_diag(0, 16'h7FFF, 16'h7FFF, 16'd0);
        gen_diag(1, 16'h7FFF, 16'h8000, 16'd0);
        push_reads_one_iter(2);
        for (int i = 0; i < N; i++) push_write(i, (i == 0) ? 32'h7FFF_FFFF : 32'd0, 1);
        for (int i = 0; i < N; i++) push_write(N + i, (i == 0) ? 32'h8000_0000 : 32'd0, 1);
        run_job(2, 1, '0, n);

        // Zero systems: done quickly with no reads
        run_job(0, 5, '0, n);
        chk(n <= 2, "zero_jobs_latency", 64'(n), 64'(2));

        // Three systems, iteration count 0 treated as 1
        for (int m = 0; m < 3; m++) gen_random(m);
        model_job(3, 0, '0);
        run_job(3, 0, '0, n);

        // Early exit with tolerance, then full 63 iterations without
        gen_random(0); gen_random(1);
        model_job(2, 63, 32'h10);
        expect_early = 1;
        run_job(2, 63, 32'h10, n);
        expect_early = 0;
        model_job(1, 63, '0);
        expect_full = 1;
        run_job(1, 63, '0, n);
        expect_full = 0;

        // Reset in the middle of a row fetch, then restart from scratch
        gen_random(0); gen_random(1);
        model_job(2, 5, '0);
        accepts = 0;
        matrix_num = 5'd2; iter_num = 6'd5; tol = '0; module_en = 1'b1;
        n = 0;
        while (!(accepts >= 3 && !mem_rreq) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(n < 2000, "reach_row_wait", 64'(n), 64'(2000));
        #2 rst_n = 1'b0;
        #1;
        chk(outs() == 64'd0, "midjob_reset_outputs", outs(), 64'd0);
        module_en = 1'b0;
        rq.delete();
        wq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_job(2, 5, '0);
        run_job(2, 5, '0, n);

        // A few random jobs with random limits and tolerances
        for (int t = 0; t < 3; t++) begin
            int mn, it;
            logic [XW-1:0] tl;
            mn = int'($urandom_range(1, 2));
            it = int'($urandom_range(1, 8));
            tl = XW'($urandom_range(0, 3) * 64);
            for (int m = 0; m < mn; m++) gen_random(m);
            model_job(mn, it, tl);
            run_job(mn, it, tl, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gsim_param.md
# gsim_param

Parametrised Gauss-Seidel linear-system solver: the next-generation successor of the fixed 16×16 solver core. It sits between the matrix memory and the result memory. For each of `i_matrix_num` systems A·x=b it fetches rows through a full rreq/rrdy handshake and iterates up to a runtime-programmable count, stopping early once converged. It then writes the saturated x vector to the result memory.

## Interface
- `N`, 16: system dimension, 2..32.
- `CW`, 16: coefficient / b width, signed.
- `XW`, 32: x width, signed Q(XW-FW).FW.
- `FW`, 16: x fractional bits.
- `RFW`, 14: reciprocal fractional bits.
- `AW`, 10: matrix-memory address width.
- `XAW`, 9: result address width.
- `MW`, 5: matrix-count width.
- `IW`, 6: iteration-count width.

Ports:
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_module_en` in 1: start; held high for the whole job.
- `i_matrix_num` in MW: number of systems.
- `i_iter_num` in IW: maximum iterations per system; 0 is treated as 1.
- `i_tol` in XW: unsigned convergence tolerance in Q.FW; 0 disables early exit.
- `o_proc_done` out 1: job complete.
- `o_mem_rreq` out 1: read request.
- `o_mem_addr` out AW: read address.
- `i_mem_rrdy` in 1: memory accepts the request this cycle.
- `i_mem_dout` in N·CW: row data; lane k is at [CW·k +: CW].
- `i_mem_dout_vld` in 1: row data valid.
- `o_x_wen` out 1: result write strobe.
- `o_x_addr` out XAW: result address.
- `o_x_iter` out IW: iterations actually run, valid with `o_x_wen`.
- `o_x_data` out XW: result value.

## Operation
- **Memory layout:** system m has base m·(N+1).
  - Row i (0..N-1) is row i of A. Lane i holds 1/a_ii in Q.RFW; the other lanes hold integer a_ij.
  - Row N holds the integer b vector.
- **States:** IDLE, LOAD_B, ROW_REQ, ROW_WAIT, CHECK, WRITE, DONE.
- **IDLE:** on `i_module_en`=1, latch `i_matrix_num`, `i_iter_num`, `i_tol`; set m=0.
  - If the latched matrix count is 0, go to DONE with no memory access.
  - Otherwise go to LOAD_B.
- **LOAD_B:** request address base+N.
  - On `vld`, store b, clear all x to 0, set iter=0, row=0, maxdelta=0.
  - Go to ROW_REQ.
- **ROW_REQ:** assert `rreq` with address base+row.
  - The request is accepted in the cycle `rreq`=`rrdy`=1; then go to ROW_WAIT.
  - Exactly one request is outstanding at a time.
- **ROW_WAIT:** on `vld`, compute x_i = sat( ((b_i<<FW) − Σ_{j≠i} a_ij·x_j) · inv_ii >> RFW ).
  - The sum uses the current x, so rows already updated this sweep are used (Gauss-Seidel).
  - Write x_i back. Set maxdelta = max(maxdelta, |x_i_new − x_i_old|).
  - If row<N-1: increment row and go to ROW_REQ. Otherwise go to CHECK.
- **CHECK (1 cycle):** increment iter.
  - If iter == iter_num, or (tol≠0 and maxdelta ≤ tol), go to WRITE.
  - Otherwise set row=0, maxdelta=0, go to ROW_REQ.
- **WRITE:** N cycles, one strobe per element i: `o_x_addr` = m·N+i, `o_x_data` = x_i, `o_x_iter` = iter.
  - Then, if m == count−1, go to DONE; otherwise increment m and go to LOAD_B.
- **DONE:** `o_proc_done`=1 while `i_module_en`=1. When `i_module_en`=0, return to IDLE.
- **Arithmetic:**
  - Products are CW+XW wide.
  - The accumulator is CW+XW+⌈log2 N⌉+1 wide.
  - Saturation happens exactly once, after the reciprocal multiply, to [−2^(XW−1), 2^(XW−1)−1].
  - Saturation rounds toward −∞ (arithmetic shift).
  - Delta is computed at XW+1 bits, unsigned.

## Timing
- **Reset values:** all outputs are 0; state=IDLE; x, b and counters cleared. Reset is asynchronous at any time, including mid-job or mid-request.
- **Registered outputs:** all outputs are registered.
- **Request hold:** `o_mem_addr` holds stable while `rreq`=1 until accepted.
- **Ignored inputs:** `vld` outside LOAD_B/ROW_WAIT is ignored. Deassertion of `i_module_en` before DONE is ignored.
- **Per-row latency:** 1 request cycle (plus `rrdy` stall) + memory latency L + 1 compute cycle. ROW_REQ is re-entered the cycle after `vld`.
- **Per-system cycles:** (L+2)·(1+iter·N) + iter + N, with `rrdy` tied high.
- **`o_x_wen`:** high for exactly N consecutive cycles per system.
- **`o_proc_done`:** rises the cycle after the last write.

## Test plan
- **Reset mid-job:** with N=16, pulse `i_rst_n` low during ROW_WAIT -> all outputs 0 and state IDLE. Re-asserting `i_module_en` restarts from m=0 and address 16.
- **Diagonal system:** A=2I (inv=0x2000), b_i=4, iter_num=1, tol=0 -> 16 writes at addr 0..15, data 0x0002_0000, `o_x_iter`=1. Check `o_proc_done`.
- **Backpressure:** hold `rrdy` low 5 cycles during ROW_REQ -> `rreq`=1 and addr constant for all 5 cycles, a single acceptance, results unchanged.
- **Early exit:** diagonally dominant 4×4 system (N=4), iter_num=63, tol=0x10 -> `o_x_iter` < 63 and results within tol of the reference model. With tol=0, `o_x_iter`=63.
- **Saturation:** b_0=32767, inv_00=0x7FFF, off-diagonal 0 -> x_0=0x7FFF_FFFF. With b_0=−32768 -> x_0=0x8000_0000.
- **Edge counts:** `i_matrix_num`=0 -> `o_proc_done` within 2 cycles, no `rreq`. With `i_matrix_num`=3, `i_iter_num`=0 -> 3 systems, 1 iteration each, addr 0..47.
